// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the writeback arbiter: source indices, default widths
// and the CDB packet type used by consumers of the broadcast.
package cdb_arbiter_pkg;

    localparam int CDB_NUM_SRC = 4;
    localparam int CDB_TAG_W   = 4;
    localparam int CDB_XLEN    = 32;

    localparam int CDB_SRC_ALU  = 0;
    localparam int CDB_SRC_MULT = 1;
    localparam int CDB_SRC_LB   = 2;
    localparam int CDB_SRC_ACU  = 3;

    typedef struct packed {
        logic                 valid;
        logic [CDB_TAG_W-1:0] tag;
        logic [CDB_XLEN-1:0]  value;
    } cdb_packet_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin priority picker: the first set request at or after ptr_i (wrapping)
// wins. Purely combinational so any select stage can reuse it.
module rr_priority_picker #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    int pos;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = |req_i;
        pos     = 0;
        // Scan farthest-first so the closest requester past the pointer is the last write.
        for (int k = N - 1; k >= 0; k--) begin
            pos = int'(ptr_i) + k;
            if (pos >= N) pos = pos - N;
            if (req_i[IW'(pos)]) idx_o = IW'(pos);
        end
        if (any_o) grant_o[idx_o] = 1'b1;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Grants one writeback packet per cycle onto the CDB (round-robin), registers the
// broadcast and keeps saturating busy/conflict counters.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter  int NUM_SRC = CDB_NUM_SRC,
    parameter  int TAG_W   = CDB_TAG_W,
    parameter  int XLEN    = CDB_XLEN,
    parameter  int CNT_W   = 32,
    localparam int IDX_W   = $clog2(NUM_SRC)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     squash,
    input  logic [NUM_SRC-1:0]       src_valid,
    input  logic [NUM_SRC*TAG_W-1:0] src_tag,
    input  logic [NUM_SRC*XLEN-1:0]  src_value,
    output logic [NUM_SRC-1:0]       src_written,
    output logic                     cdb_valid,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic [XLEN-1:0]          cdb_value,
    output logic [IDX_W-1:0]         cdb_src,
    output logic [CNT_W-1:0]         perf_busy,
    output logic [CNT_W-1:0]         perf_conflict,
    output logic [IDX_W-1:0]         rr_ptr_dbg
);

    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               cdb_valid_q;
    logic [TAG_W-1:0]   cdb_tag_q;
    logic [XLEN-1:0]    cdb_value_q;
    logic [IDX_W-1:0]   cdb_src_q;
    logic [CNT_W-1:0]   perf_busy_q, perf_conflict_q;

    logic [NUM_SRC-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic               grant;
    logic               conflict;

    rr_priority_picker #(.N(NUM_SRC)) u_picker (
        .req_i   (src_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    // Reset and squash both suppress the grant, so a held packet simply waits.
    assign grant       = pick_any && !reset && !squash;
    assign conflict    = ($countones(src_valid) >= 2) && !squash;
    assign src_written = grant ? pick_grant : '0;
    assign rr_ptr_d    = (pick_idx == IDX_W'(NUM_SRC - 1)) ? '0 : pick_idx + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_q        <= '0;
            cdb_valid_q     <= 1'b0;
            cdb_tag_q       <= '0;
            cdb_value_q     <= '0;
            cdb_src_q       <= '0;
            perf_busy_q     <= '0;
            perf_conflict_q <= '0;
        end else begin
            cdb_valid_q <= grant;
            if (grant) begin
                rr_ptr_q    <= rr_ptr_d;
                cdb_tag_q   <= src_tag[int'(pick_idx)*TAG_W +: TAG_W];
                cdb_value_q <= src_value[int'(pick_idx)*XLEN +: XLEN];
                cdb_src_q   <= pick_idx;
                if (perf_busy_q != '1) perf_busy_q <= perf_busy_q + 1'b1;
            end
            if (conflict && perf_conflict_q != '1) perf_conflict_q <= perf_conflict_q + 1'b1;
        end
    end

    assign cdb_valid     = cdb_valid_q;
    assign cdb_tag       = cdb_tag_q;
    assign cdb_value     = cdb_value_q;
    assign cdb_src       = cdb_src_q;
    assign perf_busy     = perf_busy_q;
    assign perf_conflict = perf_conflict_q;
    assign rr_ptr_dbg    = rr_ptr_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios followed by randomized traffic, checked
// against a behavioural model; a second instance with 4-bit counters covers saturation.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int TW = 4;
    localparam int XW = 32;
    localparam int IW = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          squash;
    logic [N-1:0]  src_valid;
    logic [TW-1:0] tag_a [N];
    logic [XW-1:0] val_a [N];
    logic [N*TW-1:0] src_tag;
    logic [N*XW-1:0] src_value;

    logic [N-1:0]  src_written, src_written_s;
    logic          cdb_valid, cdb_valid_s;
    logic [TW-1:0] cdb_tag, cdb_tag_s;
    logic [XW-1:0] cdb_value, cdb_value_s;
    logic [IW-1:0] cdb_src, cdb_src_s, rr_ptr_dbg, rr_ptr_dbg_s;
    logic [31:0]   perf_busy, perf_conflict;
    logic [3:0]    perf_busy_s, perf_conflict_s;

    assign src_tag   = {tag_a[3], tag_a[2], tag_a[1], tag_a[0]};
    assign src_value = {val_a[3], val_a[2], val_a[1], val_a[0]};

    always #5 clock = ~clock;

    cdb_arbiter #(.NUM_SRC(N), .TAG_W(TW), .XLEN(XW), .CNT_W(32)) dut (
        .clock(clock), .reset(reset), .squash(squash), .src_valid(src_valid),
        .src_tag(src_tag), .src_value(src_value), .src_written(src_written),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .cdb_src(cdb_src),
        .perf_busy(perf_busy), .perf_conflict(perf_conflict), .rr_ptr_dbg(rr_ptr_dbg)
    );

    cdb_arbiter #(.NUM_SRC(N), .TAG_W(TW), .XLEN(XW), .CNT_W(4)) dut_small (
        .clock(clock), .reset(reset), .squash(squash), .src_valid(src_valid),
        .src_tag(src_tag), .src_value(src_value), .src_written(src_written_s),
        .cdb_valid(cdb_valid_s), .cdb_tag(cdb_tag_s), .cdb_value(cdb_value_s), .cdb_src(cdb_src_s),
        .perf_busy(perf_busy_s), .perf_conflict(perf_conflict_s), .rr_ptr_dbg(rr_ptr_dbg_s)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int          m_rr, m_busy, m_conf, m_src, last_win;
    cdb_packet_t m_cdb;
    cdb_packet_t exp_q[$];

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic set_src(input int i, input logic [TW-1:0] t, input logic [XW-1:0] v);
        src_valid[i] = 1'b1;
        tag_a[i]     = t;
        val_a[i]     = v;
    endtask

    // One clock: check the same-cycle grant, advance, then check the registered state.
    task automatic cycle();
        int            win;
        int            nv;
        logic [N-1:0]  exp_w;
        cdb_packet_t   got;
        #1;
        win = -1;
        if (!reset && !squash)
            for (int k = 0; k < N; k++)
                if (win < 0 && src_valid[(m_rr + k) % N]) win = (m_rr + k) % N;
        exp_w = '0;
        if (win >= 0) exp_w[win] = 1'b1;
        nv = $countones(src_valid);
        check("src_written", 64'(src_written), 64'(exp_w));
        check("src_written_small", 64'(src_written_s), 64'(exp_w));
        @(posedge clock);
        #1;
        if (reset) begin
            m_rr = 0; m_busy = 0; m_conf = 0; m_src = 0;
            m_cdb = '0;
            exp_q.delete();
        end else begin
            m_cdb.valid = (win >= 0);
            if (win >= 0) begin
                m_cdb.tag   = tag_a[win];
                m_cdb.value = val_a[win];
                m_src       = win;
                m_rr        = (win + 1) % N;
                m_busy++;
                exp_q.push_back(m_cdb);
            end
            if (!squash && nv >= 2) m_conf++;
        end
        check("cdb_valid", 64'(cdb_valid), 64'(m_cdb.valid));
        check("cdb_tag", 64'(cdb_tag), 64'(m_cdb.tag));
        check("cdb_value", 64'(cdb_value), 64'(m_cdb.value));
        check("cdb_src", 64'(cdb_src), 64'(m_src));
        check("rr_ptr", 64'(rr_ptr_dbg), 64'(m_rr));
        check("perf_busy", 64'(perf_busy), 64'(m_busy));
        check("perf_conflict", 64'(perf_conflict), 64'(m_conf));
        check("perf_busy_small", 64'(perf_busy_s), 64'((m_busy > 15) ? 15 : m_busy));
        check("perf_conflict_small", 64'(perf_conflict_s), 64'((m_conf > 15) ? 15 : m_conf));
        if (cdb_valid) begin
            check("sb_pending", 64'(exp_q.size()), 64'd1);
            if (exp_q.size() > 0) begin
                got = {cdb_valid, cdb_tag, cdb_value};
                check("sb_packet", 64'(got), 64'(exp_q.pop_front()));
            end
        end
        last_win = reset ? -1 : win;
    endtask

    int order[8];
    int c0, grants1;

    initial begin
        reset = 1'b1; squash = 1'b0; src_valid = '0;
        for (int i = 0; i < N; i++) begin tag_a[i] = '0; val_a[i] = '0; end
        m_rr = 0; m_busy = 0; m_conf = 0; m_src = 0; m_cdb = '0; last_win = -1;

        // Reset: src_written must stay 0 even with a valid source
        src_valid = 4'b0101;
        cycle();
        cycle();
        src_valid = '0;
        reset = 1'b0;

        // Single packet from LB
        set_src(CDB_SRC_LB, 4'd5, 32'hDEADBEEF);
        cycle();
        check("t1_written", 64'(last_win), 64'd2);
        src_valid[2] = 1'b0;
        cycle();
        check("t1_cdb_tag", 64'(cdb_tag), 64'd5);
        check("t1_cdb_value", 64'(cdb_value), 64'hDEADBEEF);
        check("t1_cdb_src", 64'(cdb_src), 64'd2);

        // Bring the pointer back to 0 via source 3
        set_src(CDB_SRC_ACU, 4'd9, 32'h3333);
        cycle();
        src_valid[3] = 1'b0;

        // All four valid for 8 cycles
        c0 = int'(perf_conflict);
        for (int i = 0; i < N; i++) set_src(i, TW'(i), 32'h100 + i);
        for (int c = 0; c < 8; c++) begin
            cycle();
            order[c] = last_win;
            if (last_win >= 0) begin
                tag_a[last_win] = tag_a[last_win] + 4'd4;
                val_a[last_win] = val_a[last_win] + 32'h10;
            end
        end
        for (int c = 0; c < 8; c++) check("t2_order", 64'(order[c]), 64'(c % 4));
        check("t2_conflict_delta", 64'(int'(perf_conflict) - c0), 64'd8);
        src_valid = '0;

        // Pointer wrap: reach rr_ptr=3, then 3 and 0 compete
        set_src(2, 4'd1, 32'hA);
        cycle();
        src_valid = '0;
        set_src(3, 4'd2, 32'hB);
        set_src(0, 4'd3, 32'hC);
        cycle();
        check("t3_first", 64'(last_win), 64'd3);
        check("t3_rr_wrap", 64'(rr_ptr_dbg), 64'd0);
        src_valid[3] = 1'b0;
        cycle();
        check("t3_second", 64'(last_win), 64'd0);
        src_valid = '0;

        // Squash with two valid sources (rr_ptr=1 here)
        set_src(0, 4'd4, 32'hD0);
        set_src(1, 4'd6, 32'hD1);
        squash = 1'b1;
        cycle();
        check("t4_no_grant", 64'(last_win), 64'hFFFF_FFFF_FFFF_FFFF);
        check("t4_cdb_invalid", 64'(cdb_valid), 64'd0);
        check("t4_rr_hold", 64'(rr_ptr_dbg), 64'd1);
        squash = 1'b0;
        cycle();
        check("t4_resume", 64'(last_win), 64'd1);
        src_valid[1] = 1'b0;
        cycle();
        src_valid = '0;

        // Reset with a pending packet; granted exactly once afterwards
        set_src(1, 4'd7, 32'hFEED);
        reset = 1'b1;
        cycle();
        check("t6_cdb_invalid", 64'(cdb_valid), 64'd0);
        check("t6_rr_reset", 64'(rr_ptr_dbg), 64'd0);
        reset = 1'b0;
        grants1 = 0;
        cycle();
        if (last_win == 1) begin grants1++; src_valid[1] = 1'b0; end
        cycle();
        if (last_win == 1) grants1++;
        check("t6_granted_once", 64'(grants1), 64'd1);
        src_valid = '0;

        // Re-load the counters after reset and drive the small instance into saturation
        for (int c = 0; c < 20; c++) begin
            src_valid = '0;
            set_src(c % N, TW'(c), 32'(c));
            cycle();
        end
        src_valid = '0;
        check("t5_busy_saturated", 64'(perf_busy_s), 64'hF);

        // Randomized traffic obeying the source handshake
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (last_win == i) src_valid[i] = 1'b0;
                if (!src_valid[i] && $urandom_range(0, 1) == 1)
                    set_src(i, TW'($urandom_range(0, 15)), $urandom);
            end
            squash = ($urandom_range(0, 9) == 0);
            reset  = ($urandom_range(0, 59) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
